// File: rtl/count_frame_packer_if.sv
// count_frame_packer_if: byte-stream valid/ready link from the frame packer to the telemetry stage
interface count_frame_packer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    modport master(output tx_data, tx_valid, tx_last, input tx_ready);
    modport slave(input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/count_frame_packer.sv
// count_frame_packer: snapshots the count words on a cnt_done rise and streams them as hi/lo bytes plus an 8-bit sum
module count_frame_packer #(
    parameter int NWORDS = 53,
    parameter int WWIDTH = 10
) (
    input  logic                     clk50,
    input  logic                     rst,
    input  logic [NWORDS*WWIDTH-1:0] counts_flat,
    input  logic                     cnt_done,
    count_frame_packer_if.master     tx,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     ovr_clr,
    output logic [15:0]              frame_cnt
);
    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);
    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO, SEND_CSUM} state_t;
    state_t                   state;
    logic [NWORDS*WWIDTH-1:0] snap;
    logic [WWIDTH-1:0]        words [NWORDS];
    logic [WWIDTH-1:0]        cur;
    logic [WWIDTH-1:0]        nxt;
    logic [IW-1:0]            idx;
    logic [IW-1:0]            idx_n;
    logic [7:0]               csum;
    logic                     done_d;
    logic                     req;
    logic                     fire;
    for (genvar i = 0; i < NWORDS; i++) begin : g_w
        assign words[i] = snap[i*WWIDTH +: WWIDTH];
    end
    always_comb begin
        req   = cnt_done & ~done_d;
        fire  = tx.tx_valid & tx.tx_ready;
        idx_n = (idx == LAST) ? idx : idx + 1'b1;
        cur   = words[idx];
        nxt   = words[idx_n];
        busy  = state != IDLE;
    end
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            snap        <= '0;
            idx         <= '0;
            csum        <= '0;
            done_d      <= 1'b1;
            overrun     <= 1'b0;
            frame_cnt   <= '0;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
        end else begin
            done_d <= cnt_done;
            if (req && state != IDLE) overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    snap        <= counts_flat;
                    idx         <= '0;
                    csum        <= '0;
                    tx.tx_data  <= {6'b0, counts_flat[WWIDTH-1:8]};
                    tx.tx_valid <= 1'b1;
                    state       <= SEND_HI;
                end
                SEND_HI: if (fire) begin
                    csum       <= csum + tx.tx_data;
                    tx.tx_data <= cur[7:0];
                    state      <= SEND_LO;
                end
                SEND_LO: if (fire) begin
                    csum <= csum + tx.tx_data;
                    if (idx == LAST) begin
                        tx.tx_data <= csum + tx.tx_data;
                        tx.tx_last <= 1'b1;
                        state      <= SEND_CSUM;
                    end else begin
                        idx        <= idx_n;
                        tx.tx_data <= {6'b0, nxt[WWIDTH-1:8]};
                        state      <= SEND_HI;
                    end
                end
                SEND_CSUM: if (fire) begin
                    tx.tx_valid <= 1'b0;
                    tx.tx_last  <= 1'b0;
                    tx.tx_data  <= '0;
                    frame_cnt   <= frame_cnt + 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_count_frame_packer.sv
// tb_count_frame_packer: table-driven and randomized checks of the frame packer against a byte-list model
module tb_count_frame_packer;
    localparam int NW = 53;
    localparam int FW = NW * 10;
    localparam int NB = 2 * NW + 1;

    typedef struct {
        int         a;
        logic [9:0] av;
        int         b;
        logic [9:0] bv;
        logic [7:0] csum;
    } vec_t;

    logic          clk50;
    logic          rst;
    logic [FW-1:0] counts_flat;
    logic          cnt_done;
    logic          busy;
    logic          overrun;
    logic          ovr_clr;
    logic [15:0]   frame_cnt;

    count_frame_packer_if txi();

    count_frame_packer dut (
        .clk50(clk50),
        .rst(rst),
        .counts_flat(counts_flat),
        .cnt_done(cnt_done),
        .tx(txi.master),
        .busy(busy),
        .overrun(overrun),
        .ovr_clr(ovr_clr),
        .frame_cnt(frame_cnt)
    );

    int         total = 0;
    int         bad = 0;
    int         ready_pct = 100;
    int         busy_cyc = 0;
    logic [7:0] got[$];
    logic       gl[$];
    logic [7:0] exp_q[$];
    logic [15:0] exp_frames = 0;
    logic       pv = 0, pr = 0, pl = 0;
    logic [7:0] pd = 0;

    initial begin
        clk50 = 0;
        forever #5 clk50 = ~clk50;
    end

    // Monitor: checks stall stability, picks tx_ready for the coming edge, records transferred bytes.
    always @(negedge clk50) begin
        if (!rst && pv && !pr) begin
            total++;
            if (!(txi.tx_valid && txi.tx_data == pd && txi.tx_last == pl)) begin
                bad++;
                $display("FAIL stall_hold: got v=%0b d=%02h l=%0b want v=1 d=%02h l=%0b",
                         txi.tx_valid, txi.tx_data, txi.tx_last, pd, pl);
            end
        end
        txi.tx_ready = $urandom_range(99) < ready_pct;
        if (busy) busy_cyc++;
        if (txi.tx_valid && txi.tx_ready) begin
            got.push_back(txi.tx_data);
            gl.push_back(txi.tx_last);
        end
        pv = txi.tx_valid;
        pr = txi.tx_ready;
        pd = txi.tx_data;
        pl = txi.tx_last;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference frame: hi byte then lo byte of each word, then the byte sum mod 256.
    task automatic build_exp(input logic [FW-1:0] f);
        int         sum = 0;
        logic [9:0] w;
        exp_q.delete();
        for (int i = 0; i < NW; i++) begin
            w = f[i*10 +: 10];
            exp_q.push_back({6'b0, w[9:8]});
            exp_q.push_back(w[7:0]);
            sum += int'(w[9:8]) + int'(w[7:0]);
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    function automatic logic [FW-1:0] base_flat();
        logic [FW-1:0] f = '0;
        f[0 +: 10]      = 10'h3BE;
        f[10 +: 10]     = 10'h2FB;
        f[52*10 +: 10]  = 10'h2BF;
        return f;
    endfunction

    function automatic logic [FW-1:0] rand_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NW; i++) f[i*10 +: 10] = 10'($urandom);
        return f;
    endfunction

    task automatic wait_bytes(input int n, input string nm);
        int c = 0;
        while (got.size() < n && c < 4000) begin
            @(negedge clk50);
            c++;
        end
        total++;
        if (got.size() < n) begin
            bad++;
            $display("FAIL %s_timeout: got %0d bytes want %0d", nm, got.size(), n);
        end
    endtask

    task automatic cmp_frame(input string nm);
        int first = -1;
        check({nm, "_len"}, got.size(), NB);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            if (first < 0 && (got[i] !== exp_q[i] || gl[i] !== (i == NB - 1))) first = i;
        total++;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s_bytes: byte %0d got %02h last=%0b want %02h last=%0b",
                     nm, first, got[first], gl[first], exp_q[first], first == NB - 1);
        end
    endtask

    task automatic pulse_and_latency(input string nm);
        @(negedge clk50);
        cnt_done = 1;
        @(negedge clk50);
        check({nm, "_latency"}, {txi.tx_valid, busy}, 2'b11);
        cnt_done = 0;
    endtask

    task automatic run_frame(input logic [FW-1:0] f, input int pct, input string nm);
        counts_flat = f;
        build_exp(f);
        ready_pct = pct;
        got.delete();
        gl.delete();
        busy_cyc = 0;
        pulse_and_latency(nm);
        wait_bytes(NB, nm);
        repeat (3) @(negedge clk50);
        exp_frames++;
        cmp_frame(nm);
        check({nm, "_fcnt"}, frame_cnt, exp_frames);
        check({nm, "_idle"}, {busy, txi.tx_valid}, 2'b00);
        if (pct == 100) check({nm, "_busy_cycles"}, busy_cyc, NB);
    endtask

    initial begin
        vec_t          vt[6];
        logic [FW-1:0] f;
        vt[0] = '{0, 10'h3BE, 0, 10'h3BE, 8'h7F};
        vt[1] = '{2, 10'h3FF, 51, 10'h155, 8'hD7};
        vt[2] = '{0, 10'h000, 0, 10'h000, 8'hBE};
        vt[3] = '{25, 10'h0FF, 26, 10'h101, 8'h80};
        vt[4] = '{52, 10'h000, 1, 10'h000, 8'hC1};
        vt[5] = '{10, 10'h200, 10, 10'h200, 8'h81};

        rst = 1;
        cnt_done = 0;
        ovr_clr = 0;
        counts_flat = base_flat();
        repeat (3) @(negedge clk50);
        check("reset_outs", {txi.tx_valid, txi.tx_last, txi.tx_data, busy, overrun},
              {1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        check("reset_fcnt", frame_cnt, 16'h0000);
        rst = 0;
        repeat (2) @(negedge clk50);

        run_frame(base_flat(), 100, "pattern");
        check("pattern_head", {got[0], got[1], got[2], got[3]}, 32'h03BE02FB);
        check("pattern_mid", got[50], 8'h00);
        check("pattern_tail", {got[104], got[105], got[106]}, 24'h02BF7F);

        for (int k = 0; k < 6; k++) begin
            f = base_flat();
            f[vt[k].a*10 +: 10] = vt[k].av;
            f[vt[k].b*10 +: 10] = vt[k].bv;
            run_frame(f, 100, $sformatf("vec%0d", k));
            check($sformatf("vec%0d_csum", k), got[NB-1], vt[k].csum);
            if (vt[k].a == 2)
                check("counter_bytes", {got[4], got[5], got[102], got[103]}, 32'h03FF0155);
        end

        run_frame(base_flat(), 30, "backpressure");
        for (int k = 0; k < 4; k++) run_frame(rand_flat(), 30, $sformatf("rand%0d", k));

        f = rand_flat();
        counts_flat = f;
        build_exp(f);
        ready_pct = 100;
        got.delete();
        gl.delete();
        pulse_and_latency("snap");
        wait_bytes(30, "snap_a");
        counts_flat = ~f;
        wait_bytes(50, "snap_b");
        @(negedge clk50);
        cnt_done = 1;
        ovr_clr = 1;
        @(negedge clk50);
        cnt_done = 0;
        ovr_clr = 0;
        check("overrun_set_wins", overrun, 1'b1);
        wait_bytes(NB, "snap");
        repeat (150) @(negedge clk50);
        exp_frames++;
        cmp_frame("snap");
        check("snap_one_frame", got.size(), NB);
        check("snap_fcnt", frame_cnt, exp_frames);
        check("overrun_sticky", overrun, 1'b1);
        @(negedge clk50);
        ovr_clr = 1;
        @(negedge clk50);
        ovr_clr = 0;
        check("overrun_clr", overrun, 1'b0);

        rst = 1;
        cnt_done = 1;
        exp_frames = 0;
        repeat (3) @(negedge clk50);
        rst = 0;
        got.delete();
        gl.delete();
        repeat (20) @(negedge clk50);
        check("level_no_frame", {busy, txi.tx_valid}, 2'b00);
        check("level_no_bytes", got.size(), 0);
        cnt_done = 0;
        run_frame(base_flat(), 100, "pre_rst");
        got.delete();
        gl.delete();
        pulse_and_latency("rst_mid");
        wait_bytes(40, "rst_mid");
        @(negedge clk50);
        #2 rst = 1;
        #1;
        check("rst_async_valid", {txi.tx_valid, busy}, 2'b00);
        check("rst_fcnt", frame_cnt, 16'h0000);
        exp_frames = 0;
        @(negedge clk50);
        rst = 0;
        got.delete();
        gl.delete();
        repeat (2) @(negedge clk50);
        run_frame(base_flat(), 100, "post_rst");
        check("post_rst_first", got[0], 8'h03);

        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk50);
        release dut.frame_cnt;
        @(negedge clk50);
        check("wrap_pre", frame_cnt, 16'hFFFF);
        exp_frames = 16'hFFFF;
        run_frame(base_flat(), 100, "wrap");
        check("wrap_zero", frame_cnt, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/count_frame_packer.md
Name: count_frame_packer

Overview:
- Sits directly downstream of the 50-channel pulse counter array.
- On the rising edge of cnt_done it snapshots all 53 ten-bit count words, including the header and trailer words.
- It serializes the snapshot into a byte stream over a valid/ready interface, followed by an 8-bit checksum byte.
- Its output feeds the telemetry UART/FIFO stage.

Parameters:
- NWORDS, 53, number of 10-bit words per frame (word 0 is sent first).
- WWIDTH, 10, bits per count word. Fixed at 10; other values are unsupported.

Ports:
- clk50  in  1  system clock, 50 MHz; all logic is on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- counts_flat  in  530  flattened count words; word i is at [10i+9:10i] (word 0 = 0x3BE, word 1 = 0x2FB, word 52 = 0x2BF).
- cnt_done  in  1  collection-complete level from the sync timer. Its rising edge requests a frame.
- tx_data  out  8  current output byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts; a byte transfers on a clock edge where tx_valid=1 and tx_ready=1.
- tx_last  out  1  marks the checksum byte (the final byte of the frame).
- busy  out  1  a frame is in progress (state != IDLE).
- overrun  out  1  sticky: a frame request arrived while busy.
- ovr_clr  in  1  synchronous clear of overrun.
- frame_cnt  out  16  count of completed frames; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async, immediate):
  - Outputs: tx_valid=0, tx_last=0, tx_data=0, busy=0, overrun=0, frame_cnt=0.
  - Internal: state=IDLE, word index=0, checksum accumulator=0, snapshot register=0.
  - The done_d edge register resets to 1, so cnt_done already high at reset release does not start a frame.
- Edge detect:
  - done_d <= cnt_done every cycle, in every state.
  - A request is cnt_done=1 and done_d=0. A level held high never re-triggers.
- State machine: IDLE, SEND_HI, SEND_LO, SEND_CSUM.
- IDLE + request at edge N:
  - At edge N, latch all 530 bits into the snapshot register, set index=0, clear checksum, go to SEND_HI.
  - tx_valid=1 is visible after edge N (1-cycle latency from cnt_done being sampled high).
- SEND_HI: tx_data = {6'b0, word[index][9:8]}. On transfer: checksum += byte, go to SEND_LO.
- SEND_LO: tx_data = word[index][7:0]. On transfer: checksum += byte.
  - If index = NWORDS-1, go to SEND_CSUM.
  - Otherwise index+1 and go to SEND_HI.
- SEND_CSUM:
  - tx_data = checksum, which is the sum of the 2*NWORDS data bytes mod 256. tx_last=1.
  - On transfer: frame_cnt+1, go to IDLE. tx_valid=0 from the next cycle.
- Handshake rules:
  - tx_valid, tx_data and tx_last are registered.
  - While tx_valid=1 and tx_ready=0, all three hold stable.
  - tx_valid never drops without a transfer, except on reset.
  - Back-to-back transfers are allowed every cycle; the minimum frame length is 107 cycles.
  - tx_ready is ignored while tx_valid=0.
- Frame content comes from the snapshot only; counts_flat changes mid-frame do not affect the frame in progress.
- Request while state != IDLE (including the cycle the checksum transfers): the request is dropped, overrun <= 1, and the frame in progress is unaffected.
- ovr_clr and a new overrun in the same cycle: set wins (overrun stays 1).
- Reset mid-frame: the frame is abandoned with no partial completion; frame_cnt is cleared.
- busy = 1 in SEND_HI, SEND_LO and SEND_CSUM.

Test Plan:
1. Pattern frame: header/trailer words, all counters 0, tx_ready=1, pulse cnt_done.
   - Expect 107 bytes: 03 BE 02 FB, then 100 bytes of 00, then 02 BF, then checksum 7F with tx_last=1.
   - Expect frame_cnt=1, and busy high for exactly 107 cycles.
2. Counter word[2]=0x3FF, word[51]=0x155, others as in test 1.
   - Expect bytes 4-5 = 03 FF and bytes 102-103 = 01 55.
   - Expect checksum = (0x7F+0x03+0xFF+0x01+0x55) mod 256 = 0xD7.
3. Backpressure: tx_ready random at 30% duty.
   - Expect tx_data/tx_last stable while stalled, byte sequence identical to test 1, no bytes lost or duplicated.
4. Snapshot and overrun:
   - Change counts_flat mid-frame -> frame bytes are unchanged.
   - Second cnt_done edge at byte 50 -> overrun=1, only one frame is emitted.
   - ovr_clr -> overrun=0.
5. Level and reset:
   - cnt_done held high across reset release -> no frame.
   - Assert rst at byte 40 -> tx_valid=0 asynchronously and frame_cnt=0.
   - Next cnt_done edge -> complete frame, starting with byte 03.
6. Wrap: force frame_cnt to 0xFFFF, complete one frame -> frame_cnt=0x0000.
